// File: rtl/dma_periph_target_pkg.sv
// Shared remote-bus widths, FSM state encoding and the window decode helper
// for the DMA peripheral target.
package dma_periph_target_pkg;

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned STALL_W = 8;
    localparam int unsigned STAT_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dma_req_t;

    // Address hits when every bit above the window matches the base.
    function automatic logic addr_in_window(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] base,
                                            input int unsigned       bits);
        return (addr >> bits) == (base >> bits);
    endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO with full/empty flags; push and pop in one cycle are both honoured.
module dma_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dma_periph_target.sv
// Responder on the DMA remote bus: window decode, TX/RX FIFOs towards the peripheral,
// stall timeout. Define DMA_TARGET_STATS_EN to add acked-word counters.
module dma_periph_target
    import dma_periph_target_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 24'h010000,
    parameter int unsigned       WINDOW_BITS = 8,
    parameter int unsigned       FIFO_DEPTH  = 8,
    parameter int unsigned       TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              dma_err,
    output logic              periph_wvalid,
    output logic [DATA_W-1:0] periph_wdata,
    input  logic              periph_wready,
    input  logic              periph_rvalid,
    input  logic [DATA_W-1:0] periph_rdata,
    output logic              periph_rready
`ifdef DMA_TARGET_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_wr_words,
    output logic [STAT_W-1:0] stat_rd_words
`endif
);
    dma_req_t           req;
    state_e             state_q;
    state_e             state_d;
    logic [STALL_W-1:0] stall_q;
    logic               hit;
    logic               timeout_hit;
    logic               tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0]  rx_head;
    logic               tx_push, rx_pop, ack_set, err_set, stall_clr, stall_inc;

    assign req         = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
    assign hit         = dma_req && addr_in_window(req.addr, BASE_ADDR, WINDOW_BITS);
    assign timeout_hit = (stall_q == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (hit && req.we)       state_d = tx_full  ? WR_WAIT : RESP;
                else if (hit && !req.we) state_d = rx_empty ? RD_WAIT : RESP;
            end
            WR_WAIT: begin
                if (!tx_full)         state_d = RESP;
                else if (timeout_hit) state_d = IDLE;
            end
            RD_WAIT: begin
                if (!rx_empty)        state_d = RESP;
                else if (timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion only when the FIFO allows it; otherwise count the stall.
    always_comb begin
        tx_push   = 1'b0;
        rx_pop    = 1'b0;
        ack_set   = 1'b0;
        err_set   = 1'b0;
        stall_clr = 1'b0;
        stall_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_clr = 1'b1;
                if (hit && req.we && !tx_full) begin
                    tx_push = 1'b1;
                    ack_set = 1'b1;
                end else if (hit && !req.we && !rx_empty) begin
                    rx_pop  = 1'b1;
                    ack_set = 1'b1;
                end
            end
            WR_WAIT: begin
                if (!tx_full) begin
                    tx_push = 1'b1;
                    ack_set = 1'b1;
                end else if (timeout_hit) err_set = 1'b1;
                else                      stall_inc = 1'b1;
            end
            RD_WAIT: begin
                if (!rx_empty) begin
                    rx_pop  = 1'b1;
                    ack_set = 1'b1;
                end else if (timeout_hit) err_set = 1'b1;
                else                      stall_inc = 1'b1;
            end
            default: stall_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q   <= '0;
            dma_ack   <= 1'b0;
            dma_err   <= 1'b0;
            dma_rdata <= '0;
        end else begin
            dma_ack <= ack_set;
            dma_err <= err_set;
            if (rx_pop)         dma_rdata <= rx_head;
            if (stall_clr)      stall_q <= '0;
            else if (stall_inc) stall_q <= stall_q + STALL_W'(1);
        end
    end

    dma_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (req.wdata),
        .pop   (periph_wready),
        .rdata (periph_wdata),
        .full  (tx_full),
        .empty (tx_empty)
    );

    dma_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (periph_rvalid),
        .wdata (periph_rdata),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign periph_wvalid = !tx_empty;
    assign periph_rready = !rx_full;

`ifdef DMA_TARGET_STATS_EN
    // Saturating counts of acked words in each direction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_wr_words <= '0;
            stat_rd_words <= '0;
        end else begin
            if (tx_push && stat_wr_words != '1) stat_wr_words <= stat_wr_words + STAT_W'(1);
            if (rx_pop && stat_rd_words != '1)  stat_rd_words <= stat_rd_words + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dma_periph_target.sv
// Bench for dma_periph_target: directed scenarios plus a randomized phase, checked against
// a transaction-level model built from queues. Build with DMA_TARGET_STATS_EN to cover counters.
module tb_dma_periph_target;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 255;
    localparam int unsigned BASE  = 32'h0001_0000;
    localparam int unsigned WIN   = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_req;
    logic        dma_we;
    logic [23:0] dma_addr;
    logic [15:0] dma_wdata;
    logic [15:0] dma_rdata;
    logic        dma_ack;
    logic        dma_err;
    logic        periph_wvalid;
    logic [15:0] periph_wdata;
    logic        periph_wready;
    logic        periph_rvalid;
    logic [15:0] periph_rdata;
    logic        periph_rready;
`ifdef DMA_TARGET_STATS_EN
    logic [15:0] stat_wr_words;
    logic [15:0] stat_rd_words;
    int unsigned m_wr;
    int unsigned m_rd;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    logic        m_ack;
    logic        m_err;
    logic [15:0] m_rdata;
    int unsigned m_wait;
    int          n_ack = 0;
    int          n_err = 0;
    bit          rand_mode = 1'b0;

    always #5 clk = ~clk;

    dma_periph_target dut (
        .clk           (clk),
        .rst           (rst),
        .dma_req       (dma_req),
        .dma_we        (dma_we),
        .dma_addr      (dma_addr),
        .dma_wdata     (dma_wdata),
        .dma_rdata     (dma_rdata),
        .dma_ack       (dma_ack),
        .dma_err       (dma_err),
        .periph_wvalid (periph_wvalid),
        .periph_wdata  (periph_wdata),
        .periph_wready (periph_wready),
        .periph_rvalid (periph_rvalid),
        .periph_rdata  (periph_rdata),
        .periph_rready (periph_rready)
`ifdef DMA_TARGET_STATS_EN
        ,
        .stat_wr_words (stat_wr_words),
        .stat_rd_words (stat_rd_words)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input logic [23:0] a);
        int unsigned ua;
        ua = 32'(a);
        return (ua >= BASE) && (ua < BASE + WIN);
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_rdata = 16'h0000;
        m_wait  = 0;
`ifdef DMA_TARGET_STATS_EN
        m_wr = 0;
        m_rd = 0;
`endif
    endtask

    task automatic start_req(input logic we, input logic [23:0] addr, input logic [15:0] data);
        dma_we    = we;
        dma_addr  = addr;
        dma_wdata = data;
        dma_req   = 1'b1;
    endtask

    // One clock: predict from the pre-edge inputs, advance, then compare every output.
    task automatic cycle();
        bit          acc_w, acc_r, tmo, do_wpop, do_rpush;
        logic [15:0] wd, pd;
        acc_w = 1'b0;
        acc_r = 1'b0;
        tmo   = 1'b0;
        wd    = dma_wdata;
        pd    = periph_rdata;
        if (dma_req && in_window(dma_addr) && !m_ack) begin
            if (dma_we && tx_q.size() < DEPTH)       acc_w = 1'b1;
            else if (!dma_we && rx_q.size() > 0)     acc_r = 1'b1;
            else begin
                m_wait++;
                if (m_wait == TMO + 1) tmo = 1'b1;
            end
        end
        do_wpop  = periph_wready && tx_q.size() > 0;
        do_rpush = periph_rvalid && rx_q.size() < DEPTH;
        @(posedge clk);
        #1;
        if (do_wpop) void'(tx_q.pop_front());
        if (acc_r)   m_rdata = rx_q.pop_front();
        if (acc_w)   tx_q.push_back(wd);
        if (do_rpush) rx_q.push_back(pd);
        m_ack = acc_w || acc_r;
        m_err = tmo;
`ifdef DMA_TARGET_STATS_EN
        if (acc_w && m_wr < 32'hFFFF) m_wr++;
        if (acc_r && m_rd < 32'hFFFF) m_rd++;
        check("stat_wr", 32'(stat_wr_words), m_wr);
        check("stat_rd", 32'(stat_rd_words), m_rd);
`endif
        if (m_ack || m_err) begin
            dma_req = 1'b0;
            m_wait  = 0;
        end
        n_ack += int'(dma_ack);
        n_err += int'(dma_err);
        check("ack", 32'(dma_ack), 32'(m_ack));
        check("err", 32'(dma_err), 32'(m_err));
        check("rdata", 32'(dma_rdata), 32'(m_rdata));
        check("wvalid", 32'(periph_wvalid), 32'(tx_q.size() != 0));
        if (tx_q.size() != 0) check("wdata", 32'(periph_wdata), 32'(tx_q[0]));
        check("rready", 32'(periph_rready), 32'(tx_q.size() >= 0 && rx_q.size() < DEPTH));
        if (rand_mode) begin
            periph_wready = 1'($urandom_range(0, 1));
            periph_rvalid = 1'($urandom_range(0, 1));
            periph_rdata  = 16'($urandom);
        end
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n;
        n = 0;
        while (dma_req && n < bound) begin
            cycle();
            n++;
        end
        check(tag, 32'(dma_req), 32'd0);
    endtask

    initial begin
        int a0, e0;
        logic [23:0] addr;
        logic        we;
        rst           = 1'b0;
        dma_req       = 1'b0;
        dma_we        = 1'b0;
        dma_addr      = 24'h0;
        dma_wdata     = 16'h0;
        periph_wready = 1'b0;
        periph_rvalid = 1'b0;
        periph_rdata  = 16'h0;
        model_reset();

        #12;
        check("rst_ack", 32'(dma_ack), 32'd0);
        check("rst_err", 32'(dma_err), 32'd0);
        check("rst_rdata", 32'(dma_rdata), 32'd0);
        check("rst_wvalid", 32'(periph_wvalid), 32'd0);
        check("rst_rready", 32'(periph_rready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Unstalled write: ack one cycle after the request.
        start_req(1'b1, 24'h010004, 16'hBEEF);
        cycle();
        check("t1_ack", 32'(dma_ack), 32'd1);
        check("t1_wvalid", 32'(periph_wvalid), 32'd1);
        check("t1_wdata", 32'(periph_wdata), 32'h0000BEEF);

        // Fill TX, then a ninth write stalls until the peripheral drains.
        for (int i = 0; i < 8 && tx_q.size() < DEPTH; i++) begin
            start_req(1'b1, 24'(BASE + 2 * i), 16'hA000 + 16'(i));
            wait_done("t2_fill_done", 4);
        end
        check("t2_full_rready_tx", 32'(periph_wvalid), 32'd1);
        a0 = n_ack;
        start_req(1'b1, 24'h0100FE, 16'h9999);
        repeat (10) cycle();
        check("t2_stall_no_ack", 32'(n_ack - a0), 32'd0);
        periph_wready = 1'b1;
        wait_done("t2_unstall_done", 20);
        check("t2_unstall_ack", 32'(n_ack - a0), 32'd1);
        repeat (12) cycle();
        periph_wready = 1'b0;
        check("t2_drained", 32'(periph_wvalid), 32'd0);

        // Read stalls on empty RX until the peripheral offers a word.
        a0 = n_ack;
        start_req(1'b0, 24'h010000, 16'h0);
        repeat (5) cycle();
        periph_rvalid = 1'b1;
        periph_rdata  = 16'h1234;
        cycle();
        periph_rvalid = 1'b0;
        wait_done("t3_done", 10);
        check("t3_ack", 32'(n_ack - a0), 32'd1);
        check("t3_rdata", 32'(dma_rdata), 32'h00001234);

        // Read with nothing arriving times out with a single error pulse.
        a0 = n_ack;
        e0 = n_err;
        start_req(1'b0, 24'h010010, 16'h0);
        wait_done("t4_done", 300);
        check("t4_err_once", 32'(n_err - e0), 32'd1);
        check("t4_no_ack", 32'(n_ack - a0), 32'd0);
        cycle();
        check("t4_err_low", 32'(dma_err), 32'd0);

        // Another target's address is never answered.
        a0 = n_ack;
        e0 = n_err;
        start_req(1'b1, 24'h020000, 16'h5555);
        repeat (300) cycle();
        dma_req = 1'b0;
        check("t5_no_ack", 32'(n_ack - a0), 32'd0);
        check("t5_no_err", 32'(n_err - e0), 32'd0);
        check("t5_tx_empty", 32'(periph_wvalid), 32'd0);

        // Randomized traffic including window edges and odd addresses.
        rand_mode = 1'b1;
        for (int t = 0; t < 150; t++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       addr = 24'h0100FF;
                1:       addr = 24'h010100;
                2:       addr = 24'h00FFFF;
                default: addr = 24'(BASE + $urandom_range(0, WIN - 1));
            endcase
            start_req(we, addr, 16'($urandom));
            if (in_window(addr)) begin
                wait_done("rand_done", 600);
            end else begin
                repeat (4) cycle();
                dma_req = 1'b0;
            end
            cycle();
        end
        rand_mode     = 1'b0;
        periph_wready = 1'b0;
        periph_rvalid = 1'b1;
        periph_rdata  = 16'hCAFE;
        repeat (10) cycle();
        periph_rvalid = 1'b0;
        check("r_rx_full", 32'(periph_rready), 32'd0);

        // Reset while a write is stalled on a full TX FIFO.
        for (int i = 0; i < 9 && tx_q.size() < DEPTH; i++) begin
            start_req(1'b1, 24'(BASE + 4 * i), 16'hC000 + 16'(i));
            wait_done("t6_fill_done", 4);
        end
        start_req(1'b1, 24'h010020, 16'h7777);
        repeat (3) cycle();
        check("t6_stalled_wvalid", 32'(periph_wvalid), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_ack", 32'(dma_ack), 32'd0);
        check("t6_err", 32'(dma_err), 32'd0);
        check("t6_wvalid", 32'(periph_wvalid), 32'd0);
        check("t6_rready", 32'(periph_rready), 32'd1);
        check("t6_rdata", 32'(dma_rdata), 32'd0);
`ifdef DMA_TARGET_STATS_EN
        check("t6_stat_wr", 32'(stat_wr_words), 32'd0);
        check("t6_stat_rd", 32'(stat_rd_words), 32'd0);
`endif
        dma_req = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start_req(1'b1, 24'h010002, 16'h4321);
        cycle();
        check("t6_post_ack", 32'(dma_ack), 32'd1);
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
